// File: rtl/exe_pkg.sv
// Shared EXE-stage definitions: shift-type encoding (same as Shift_operand[6:5])
// and the shift sequencer state encoding / iteration-count helper.
package exe_pkg;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } seq_state_t;

  // Number of one-bit steps needed to reproduce the ARM register-shift result.
  // LSL/LSR clamp at width+1 (one extra step flushes the carry to 0),
  // ASR saturates at width (all sign bits), ROR only cares about amt mod width.
  function automatic int unsigned iter_count(input int unsigned amt,
                                             input logic [1:0]  typ,
                                             input int unsigned width);
    int unsigned n;
    case (typ)
      SHIFT_ASR: n = (amt > width) ? width : amt;
      SHIFT_ROR: n = amt % width;
      default:   n = (amt > width + 1) ? width + 1 : amt;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/exe_shift_sequencer_if.sv
// Request/response bundle between the EXE stage and the shift sequencer.
interface exe_shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_rm;
  logic [AMT_W-1:0] req_amt;
  logic [1:0]       req_type;
  logic             req_carry_in;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_value;
  logic             resp_carry;

  // EXE side: issues requests, consumes results
  modport master (
    output req_valid, req_rm, req_amt, req_type, req_carry_in, resp_ready,
    input  req_ready, resp_valid, resp_value, resp_carry
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_rm, req_amt, req_type, req_carry_in, resp_ready,
    output req_ready, resp_valid, resp_value, resp_carry
  );
endinterface

// File: rtl/exe_shift_sequencer_shift_step.sv
// Combinational single-bit shift step; bit_o is the bit leaving the operand
// (for ROR, the bit wrapping around into the MSB).
module shift_step
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic [1:0]       type_i,
  output logic [WIDTH-1:0] val_o,
  output logic             bit_o
);

  // One step of the selected shift type
  always_comb begin
    val_o = val_i;
    bit_o = val_i[0];
    case (type_i)
      SHIFT_LSL: begin
        val_o = {val_i[WIDTH-2:0], 1'b0};
        bit_o = val_i[WIDTH-1];
      end
      SHIFT_LSR: val_o = {1'b0, val_i[WIDTH-1:1]};
      SHIFT_ASR: val_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
      default:   val_o = {val_i[0], val_i[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/exe_shift_sequencer.sv
// Multi-cycle shift-by-register sequencer for the EXE stage. Shifts one bit per
// cycle and presents Val2 plus shifter carry under a valid/ready handshake.
module exe_shift_sequencer
  import exe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AMT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  exe_shift_sequencer_if.slave bus,
  output logic                 busy
);

  // Count must hold WIDTH+1 (LSL/LSR past the operand width)
  localparam int CNT_W = $clog2(WIDTH + 2);

  seq_state_t       state_q;
  logic [WIDTH-1:0] val_q;
  logic             carry_q;
  logic [1:0]       type_q;
  logic [CNT_W-1:0] cnt_q;
  logic             resp_valid_q;
  logic             busy_q;

  logic [CNT_W-1:0] cnt_d;
  logic             carry_d;
  logic             accept;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .val_i  (val_q),
    .type_i (type_q),
    .val_o  (step_val),
    .bit_o  (step_bit)
  );

  // Load values for an incoming request: step count and the carry that holds
  // when no step runs (amt=0 keeps C; ROR by a multiple of WIDTH gives the MSB)
  always_comb begin
    cnt_d   = CNT_W'(iter_count(32'(bus.req_amt), bus.req_type, WIDTH));
    carry_d = bus.req_carry_in;
    if (bus.req_amt != '0 && bus.req_type == SHIFT_ROR)
      carry_d = bus.req_rm[WIDTH-1];
  end

  // Ready in IDLE, or in DONE when the result leaves this cycle (back-to-back)
  assign bus.req_ready = rst_n &
                         ((state_q == ST_IDLE) ||
                          (state_q == ST_DONE && bus.resp_ready));

  // A flush drops any same-cycle request
  assign accept = bus.req_valid & bus.req_ready & ~flush;

  // Sequencer FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      val_q        <= '0;
      carry_q      <= 1'b0;
      type_q       <= SHIFT_LSL;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else if (flush) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SHIFT: begin
          val_q   <= step_val;
          carry_q <= step_bit;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= ST_DONE;
            resp_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      // Accept overrides the DONE->IDLE exit so results stream without a bubble
      if (accept) begin
        val_q        <= bus.req_rm;
        type_q       <= bus.req_type;
        carry_q      <= carry_d;
        cnt_q        <= cnt_d;
        busy_q       <= 1'b1;
        if (cnt_d == '0) begin
          state_q      <= ST_DONE;
          resp_valid_q <= 1'b1;
        end else begin
          state_q      <= ST_SHIFT;
          resp_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_value = val_q;
  assign bus.resp_carry = carry_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_exe_shift_sequencer.sv
// Bench for exe_shift_sequencer: directed vector table, randomized requests
// against an ARM-shift reference model, and hand sequences for back-to-back,
// flush and asynchronous reset.
module tb_exe_shift_sequencer;
  import exe_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  exe_shift_sequencer_if #(.WIDTH(32), .AMT_W(8)) bus ();

  exe_shift_sequencer #(.WIDTH(32), .AMT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    logic [31:0] rm;
    logic [7:0]  amt;
    logic [1:0]  typ;
    logic        cin;
    logic [31:0] ev;
    logic        ec;
    int unsigned lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ARM register-shift result from the architectural definition
  function automatic void model(input logic [31:0] rm, input int unsigned amt,
                                input logic [1:0] typ, input logic cin,
                                output logic [31:0] v, output logic c,
                                output int unsigned lat);
    int unsigned n;
    int unsigned r;
    v = rm;
    c = cin;
    n = 0;
    case (typ)
      SHIFT_LSL: begin
        n = (amt > 33) ? 33 : amt;
        if (amt == 0) ;
        else if (amt < 32) begin v = rm << amt; c = rm[5'(32 - amt)]; end
        else if (amt == 32) begin v = '0; c = rm[0]; end
        else begin v = '0; c = 1'b0; end
      end
      SHIFT_LSR: begin
        n = (amt > 33) ? 33 : amt;
        if (amt == 0) ;
        else if (amt < 32) begin v = rm >> amt; c = rm[5'(amt - 1)]; end
        else if (amt == 32) begin v = '0; c = rm[31]; end
        else begin v = '0; c = 1'b0; end
      end
      SHIFT_ASR: begin
        n = (amt > 32) ? 32 : amt;
        if (amt == 0) ;
        else if (amt < 32) begin v = $signed(rm) >>> amt; c = rm[5'(amt - 1)]; end
        else begin v = {32{rm[31]}}; c = rm[31]; end
      end
      default: begin
        r = amt % 32;
        n = r;
        if (amt == 0) ;
        else if (r == 0) c = rm[31];
        else begin v = (rm >> r) | (rm << (32 - r)); c = rm[5'(r - 1)]; end
      end
    endcase
    lat = n + 1;
  endfunction

  // Issue one request, measure latency, check result, optionally stall, retire
  task automatic run_req(input string name, input logic [31:0] rm, input logic [7:0] amt,
                         input logic [1:0] typ, input logic cin, input logic [31:0] ev,
                         input logic ec, input int unsigned elat, input int hold);
    int lat;
    int w;
    w = 0;
    while (!bus.req_ready && w < 50) begin tick(); w++; end
    check({name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_rm       = rm;
    bus.req_amt      = amt;
    bus.req_type     = typ;
    bus.req_carry_in = cin;
    tick();
    // inputs are only sampled at the accept edge
    bus.req_valid    = 1'b0;
    bus.req_rm       = $urandom;
    bus.req_amt      = 8'($urandom);
    bus.req_type     = 2'($urandom);
    bus.req_carry_in = ~cin;
    lat = 1;
    while (!bus.resp_valid && lat < 100) begin tick(); lat++; end
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " value"}, bus.resp_value, ev);
    check({name, " carry"}, 32'(bus.resp_carry), 32'(ec));
    check({name, " busy"}, 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) tick();
    if (hold > 0) begin
      check({name, " held value"}, bus.resp_value, ev);
      check({name, " held valid"}, 32'(bus.resp_valid), 32'd1);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({name, " valid drop"}, 32'(bus.resp_valid), 32'd0);
    check({name, " busy drop"}, 32'(busy), 32'd0);
  endtask

  task automatic run_model(input string name, input logic [31:0] rm, input logic [7:0] amt,
                           input logic [1:0] typ, input logic cin, input int hold);
    logic [31:0] ev;
    logic ec;
    int unsigned lat;
    model(rm, 32'(amt), typ, cin, ev, ec, lat);
    run_req(name, rm, amt, typ, cin, ev, ec, lat, hold);
  endtask

  initial begin
    vecs[0] = '{"lsl4",    32'h000000F1, 8'd4,  SHIFT_LSL, 1'b0, 32'h00000F10, 1'b0, 5};
    vecs[1] = '{"lsr0",    32'h80000001, 8'd0,  SHIFT_LSR, 1'b1, 32'h80000001, 1'b1, 1};
    vecs[2] = '{"asr40",   32'h80000000, 8'd40, SHIFT_ASR, 1'b0, 32'hFFFFFFFF, 1'b1, 33};
    vecs[3] = '{"lsl32",   32'hFFFFFFFF, 8'd32, SHIFT_LSL, 1'b0, 32'h00000000, 1'b1, 33};
    vecs[4] = '{"lsl33",   32'hFFFFFFFF, 8'd33, SHIFT_LSL, 1'b0, 32'h00000000, 1'b0, 34};
    vecs[5] = '{"ror32",   32'h80000001, 8'd32, SHIFT_ROR, 1'b0, 32'h80000001, 1'b1, 1};
    vecs[6] = '{"ror36",   32'h0000000F, 8'd36, SHIFT_ROR, 1'b0, 32'hF0000000, 1'b1, 5};
    vecs[7] = '{"lsr32",   32'h80000000, 8'd32, SHIFT_LSR, 1'b0, 32'h00000000, 1'b1, 33};
    vecs[8] = '{"asr1",    32'h80000003, 8'd1,  SHIFT_ASR, 1'b0, 32'hC0000001, 1'b1, 2};

    rst_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rm = '0;
    bus.req_amt = '0;
    bus.req_type = SHIFT_LSL;
    bus.req_carry_in = 1'b0;
    bus.resp_ready = 1'b0;

    // reset state
    #2;
    check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check("reset resp_value", bus.resp_value, 32'd0);
    check("reset resp_carry", 32'(bus.resp_carry), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    #20;
    rst_n = 1'b1;
    tick();
    check("reset req_ready", 32'(bus.req_ready), 32'd1);

    // directed vector table
    foreach (vecs[i])
      run_req(vecs[i].name, vecs[i].rm, vecs[i].amt, vecs[i].typ, vecs[i].cin,
              vecs[i].ev, vecs[i].ec, vecs[i].lat, i % 3);

    // randomized requests against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [7:0] amt;
      amt = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      run_model("rand", $urandom, amt, 2'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    // back-to-back with resp_ready high: LSR 1 then LSL 2 on 0x3
    bus.resp_ready   = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_rm       = 32'h3;
    bus.req_amt      = 8'd1;
    bus.req_type     = SHIFT_LSR;
    bus.req_carry_in = 1'b0;
    tick();
    check("b2b busy in shift", 32'(busy), 32'd1);
    check("b2b ready in shift", 32'(bus.req_ready), 32'd0);
    bus.req_amt  = 8'd2;
    bus.req_type = SHIFT_LSL;
    tick();
    check("b2b first valid", 32'(bus.resp_valid), 32'd1);
    check("b2b first value", bus.resp_value, 32'h1);
    check("b2b first carry", 32'(bus.resp_carry), 32'd1);
    check("b2b ready in done", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    check("b2b second accepted", 32'(busy), 32'd1);
    check("b2b valid gap", 32'(bus.resp_valid), 32'd0);
    tick();
    tick();
    check("b2b second valid", 32'(bus.resp_valid), 32'd1);
    check("b2b second value", bus.resp_value, 32'hC);
    check("b2b second carry", 32'(bus.resp_carry), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall value", bus.resp_value, 32'hC);
      check("stall valid", 32'(bus.resp_valid), 32'd1);
      check("stall busy", 32'(busy), 32'd1);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("b2b retire", 32'(bus.resp_valid), 32'd0);

    // flush mid-shift (LSL 20)
    bus.req_valid = 1'b1;
    bus.req_rm    = 32'hFFFFFFFF;
    bus.req_amt   = 8'd20;
    bus.req_type  = SHIFT_LSL;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("flush busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush ready", 32'(bus.req_ready), 32'd1);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 25; i++) begin tick(); seen += int'(bus.resp_valid); end
      check("flush no resp", 32'(seen), 32'd0);
    end
    run_model("after flush", 32'h12345678, 8'd7, SHIFT_ROR, 1'b0, 0);

    // flush in DONE with resp_ready and a new request: request dropped
    bus.req_valid = 1'b1;
    bus.req_rm    = 32'hA5A5A5A5;
    bus.req_amt   = 8'd0;
    bus.req_type  = SHIFT_LSR;
    tick();
    check("flush-done valid", 32'(bus.resp_valid), 32'd1);
    bus.req_amt    = 8'd1;
    bus.resp_ready = 1'b1;
    flush          = 1'b1;
    tick();
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    check("flush-done valid drop", 32'(bus.resp_valid), 32'd0);
    check("flush-done busy", 32'(busy), 32'd0);
    tick();
    tick();
    tick();
    check("flush-done dropped req", 32'(bus.resp_valid), 32'd0);

    // asynchronous reset mid-shift
    bus.req_valid = 1'b1;
    bus.req_rm    = 32'hFFFFFFFF;
    bus.req_amt   = 8'd20;
    bus.req_type  = SHIFT_LSL;
    bus.req_carry_in = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre-reset value shifting", 32'(bus.resp_value != 32'd0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset value", bus.resp_value, 32'd0);
    check("async reset carry", 32'(bus.resp_carry), 32'd0);
    check("async reset valid", 32'(bus.resp_valid), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post-reset ready", 32'(bus.req_ready), 32'd1);
    run_model("after reset", 32'h0000F00F, 8'd3, SHIFT_LSR, 1'b1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
